// File: rtl/wired_bus_arbiter_pkg.sv
// Shared types and helpers for the wired-bus arbiter and related shared-net controllers.
package wired_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } arb_state_e;

  localparam int unsigned TIMEOUT_DEFAULT = 15;

  // Index following idx in a ring of n requesters.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wired_bus_arbiter_if.sv
// Request/grant bundle between the requesters and the wired-bus arbiter.
interface wired_bus_if #(
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] drv_en;
  logic [ID_W-1:0]  owner;
  logic             bus_busy;
  logic             timeout_pulse;

  modport master (
    input  req, done,
    output gnt, drv_en, owner, bus_busy, timeout_pulse
  );

  modport slave (
    output req, done,
    input  gnt, drv_en, owner, bus_busy, timeout_pulse
  );
endinterface

// File: rtl/wired_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            valid,
  output logic [ID_W-1:0] index
);

  logic [ID_W-1:0] idx;

  // Scan from the far end so the candidate closest to ptr is written last and wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    idx   = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = ID_W'((32'(ptr) + 32'(i)) % N);
      if (req[idx]) begin
        valid = 1'b1;
        index = idx;
      end
    end
  end

endmodule

// File: rtl/wired_bus_arbiter.sv
// Round-robin owner selection for a shared wired bus, with a dead cycle between owners.
module wired_bus_arbiter
  import wired_bus_pkg::*;
#(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input logic        clk,
  input logic        rst_n,
  wired_bus_if.master bus
);

  localparam int unsigned ID_W  = $clog2(N_REQ);
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT);

  arb_state_e       state_q, state_n;
  logic [N_REQ-1:0] gnt_q, gnt_n, drv_q;
  logic [ID_W-1:0]  owner_q, owner_n, ptr_q, ptr_n, pick_idx;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic             busy_q, tp_q, tp_n, pick_valid;
  logic             rel_done, rel_req, rel_to;

  rr_pick #(.N(N_REQ), .ID_W(ID_W)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n  = state_q;
    gnt_n    = gnt_q;
    owner_n  = owner_q;
    ptr_n    = ptr_q;
    cnt_n    = cnt_q;
    tp_n     = 1'b0;
    rel_done = bus.done[owner_q];
    rel_req  = ~bus.req[owner_q];
    rel_to   = (TIMEOUT != 0) && (cnt_q == TO_VAL);
    case (state_q)
      GRANT: begin
        if (rel_done || rel_req || rel_to) begin
          state_n = TURN;
          gnt_n   = '0;
          ptr_n   = ID_W'(rr_next(32'(owner_q), N_REQ));
          cnt_n   = '0;
          tp_n    = rel_to && !rel_done && !rel_req;
        end else if (cnt_q != CNT_MAX) begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        // IDLE and TURN both arbitrate; TURN always lasts one cycle.
        if (pick_valid) begin
          state_n = GRANT;
          gnt_n   = N_REQ'(1) << pick_idx;
          owner_n = pick_idx;
          cnt_n   = CNT_W'(1);
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      drv_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      tp_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      gnt_q   <= gnt_n;
      drv_q   <= gnt_n;
      owner_q <= owner_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
      busy_q  <= (state_n != IDLE);
      tp_q    <= tp_n;
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.drv_en        = drv_q;
  assign bus.owner         = owner_q;
  assign bus.bus_busy      = busy_q;
  assign bus.timeout_pulse = tp_q;

endmodule

// File: doc/wired_bus_arbiter.md
Name: wired_bus_arbiter

Overview:
Round-robin arbiter that shares one multi-driven tri/wor bus between N_REQ requesters. Exactly one requester drives the bus at a time. A mandatory one-cycle turnaround separates any two owners, so resolved nets never see overlapping drivers. It sits beside the shared-net datapath and produces the per-driver output enables.

Parameters:
N_REQ, 4, number of requesters (2..16)
ID_W, $clog2(N_REQ), width of owner index (derived, not overridden)
TIMEOUT, 15, max consecutive grant cycles per owner; 0 disables forced release (range 0..255)

Ports:
clk  input  1  sole clock, rising edge
rst_n  input  1  reset, asynchronous assert, active-low
req  input  N_REQ  per-requester bus request, level
done  input  N_REQ  per-requester release strobe; only bit [owner] is honoured
gnt  output  N_REQ  one-hot grant, registered
drv_en  output  N_REQ  bus output enable; equals gnt (registered copy, separate port for fan-out)
owner  output  ID_W  index of current grant holder; holds last owner when idle
bus_busy  output  1  high in GRANT and TURN
timeout_pulse  output  1  one-cycle pulse on the cycle after a forced release

Behaviour:
- Reset (rst_n low, async): state=IDLE, gnt=0, drv_en=0, owner=0, bus_busy=0, timeout_pulse=0, rr pointer=0, hold counter=0. Outputs stay at these values for the whole time rst_n is low. Reset mid-grant drops gnt and drv_en immediately, without waiting for a clock.
- All outputs are registered; none is combinational from any input.
- States: IDLE, GRANT, TURN.
- Arbitration, evaluated in IDLE and TURN: scan req starting at index ptr and wrap modulo N_REQ. First set bit wins. No req set means no grant.
- IDLE: any req at edge t -> GRANT; gnt[w]=1, drv_en[w]=1, owner=w visible after edge t (latency 1). Otherwise stay in IDLE.
- GRANT: hold counter starts at 1 on the first grant cycle and increments each cycle. Release at edge t if any of the following holds:
  - done[owner]=1
  - req[owner]=0
  - TIMEOUT!=0 and counter==TIMEOUT
- On release: next state TURN; gnt=0, drv_en=0 after edge t; ptr=(owner+1) mod N_REQ; counter cleared. timeout_pulse=1 during TURN only if the timeout was the sole release cause.
- TURN: always exactly one cycle with no driver. At its exit edge, arbitrate using the updated ptr: a winner -> GRANT, otherwise -> IDLE.
- Handover latency from release edge to next gnt: 2 edges (one dead cycle).
- done or req on non-owner bits are ignored during GRANT. done in IDLE/TURN is ignored.
- Owner keeps req high and asserts no done: it is re-granted only after TURN and only if round-robin reaches it again (no back-to-back monopoly when others request).
- Single requester keeps requesting with TIMEOUT=T: pattern is T grant cycles, 1 TURN cycle, repeating.
- Invariants: popcount(gnt)<=1 always; gnt==drv_en always; gnt!=0 implies state GRANT.
- Counter width 8 bits, saturating; no wrap when TIMEOUT=0.

Decomposition:
- Package wired_bus_pkg:
  - arb_state_e enum {IDLE, GRANT, TURN} (2-bit)
  - localparam function for the round-robin next-index computation
  - default TIMEOUT constant
- One sub-module, rr_pick: combinational masked priority picker. Inputs req and ptr; outputs valid and index. It is reused by later shared-net controllers.

Test Plan:
- Reset check: rst_n low with req=4'b1111 -> gnt=0, drv_en=0, bus_busy=0. Release reset, req=4'b0100 held -> gnt=4'b0100, owner=2 one edge later.
- Round-robin: req=4'b1111 held, each owner strobes done on its 3rd grant cycle -> grant order 0,1,2,3,0 with exactly one gnt=0 cycle between owners.
- Timeout: TIMEOUT=4, req=4'b0011 held, no done -> owner0 for 4 cycles, TURN with timeout_pulse=1, owner1 for 4 cycles, then owner0.
- Requester drop: owner=1, req[1] falls at edge t -> gnt=0 after t. req=4'b1001 pending -> gnt=4'b1000 (owner 3) after t+1.
- Async reset mid-grant: rst_n falls between edges while gnt=4'b0010 -> gnt and drv_en 0 before the next edge. After release, ptr=0, so req=4'b1010 grants owner 1.
- Invariant sweep: 10k cycles of random req/done with TIMEOUT in {0,1,15} -> popcount(gnt)<=1, gnt==drv_en, no gnt in the cycle immediately after any release.
